// File: rtl/seq_decoder.sv
// Instruction decoder/control unit: opcode decode, SW8 synchroniser/debouncer,
// multi-cycle multiply stall FSM and sticky illegal-opcode flag.
package cpuConfig;
    typedef enum logic [5:0] {
        OP_LDI   = 6'd0,
        OP_LDS   = 6'd1,
        OP_ADD   = 6'd2,
        OP_ADDI  = 6'd3,
        OP_WAIT0 = 6'd4,
        OP_WAIT1 = 6'd5,
        OP_MUL   = 6'd6,
        OP_MULI  = 6'd7
    } opCode_t;

    typedef enum logic [1:0] {
        ALU_A   = 2'd0,
        ALU_B   = 2'd1,
        ALU_ADD = 2'd2,
        ALU_MUL = 2'd3
    } aluFunc_t;
endpackage

module seq_decoder #(
    parameter int O_SIZE          = 6,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MUL_CYCLES      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [O_SIZE-1:0] opCode,
    input  logic              demoSwitch,
    output logic [1:0]        aluFunc,
    output logic              aluImmediate,
    output logic              immSwitches,
    output logic              pcInc,
    output logic              writeReg,
    output logic              busy,
    output logic              illegalOp
);
    import cpuConfig::*;

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_sync;
    logic                   sw_db;
    logic [DB_W-1:0]        db_cnt;

    aluFunc_t fn;
    logic     imm, isw, pc, wr, bsy, is_mul, illegal;

    assign sw_sync      = sync_q[SYNC_STAGES-1];
    assign aluFunc      = fn;
    assign aluImmediate = imm;
    assign immSwitches  = isw;
    assign pcInc        = pc;
    assign writeReg     = wr;
    assign busy         = bsy;

    always_comb begin
        fn      = ALU_A;
        imm     = 1'b0;
        isw     = 1'b0;
        pc      = 1'b1;
        wr      = 1'b1;
        bsy     = 1'b0;
        is_mul  = 1'b0;
        illegal = 1'b0;
        case (opCode)
            O_SIZE'(OP_LDI):   begin fn = ALU_B; imm = 1'b1; end
            O_SIZE'(OP_LDS):   begin fn = ALU_B; imm = 1'b1; isw = 1'b1; pc = sw_db; end
            O_SIZE'(OP_ADD):   fn = ALU_ADD;
            O_SIZE'(OP_ADDI):  begin fn = ALU_ADD; imm = 1'b1; end
            O_SIZE'(OP_WAIT0): pc = ~sw_db;
            O_SIZE'(OP_WAIT1): pc = sw_db;
            O_SIZE'(OP_MUL):   begin fn = ALU_MUL; is_mul = 1'b1; end
            O_SIZE'(OP_MULI):  begin fn = ALU_MUL; imm = 1'b1; is_mul = 1'b1; end
            default:           begin wr = 1'b0; illegal = 1'b1; end
        endcase
        // Stall every multiply cycle except the last; the final cycle keeps the default write/advance.
        if (state == MUL_BUSY) begin
            if (cnt != '0) begin
                pc  = 1'b0;
                wr  = 1'b0;
                bsy = 1'b1;
            end
        end else if (is_mul && (MUL_CYCLES > 1)) begin
            pc  = 1'b0;
            wr  = 1'b0;
            bsy = 1'b1;
        end
        if (reset) begin
            fn  = ALU_A;
            imm = 1'b0;
            isw = 1'b0;
            pc  = 1'b0;
            wr  = 1'b0;
            bsy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sync_q    <= '0;
            sw_db     <= 1'b0;
            db_cnt    <= '0;
            illegalOp <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], demoSwitch};
            illegalOp <= illegalOp | illegal;

            if (sw_sync == sw_db) begin
                db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
                sw_db  <= sw_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end

            case (state)
                IDLE: begin
                    if (is_mul && (MUL_CYCLES > 1)) begin
                        state <= MUL_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                MUL_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder with MUL_CYCLES=3 and default sync/debounce depths.
module tb_seq_decoder;
    import cpuConfig::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode;
    logic       demoSwitch;
    logic [1:0] aluFunc;
    logic       aluImmediate, immSwitches, pcInc, writeReg, busy, illegalOp;
    logic [5:0] ctl;

    int total = 0;
    int bad   = 0;

    seq_decoder #(
        .O_SIZE(6),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .MUL_CYCLES(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .opCode(opCode),
        .demoSwitch(demoSwitch),
        .aluFunc(aluFunc),
        .aluImmediate(aluImmediate),
        .immSwitches(immSwitches),
        .pcInc(pcInc),
        .writeReg(writeReg),
        .busy(busy),
        .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    assign ctl = {aluFunc, aluImmediate, immSwitches, pcInc, writeReg};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] exp; // {aluFunc, aluImmediate, immSwitches, pcInc, writeReg}
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_count;
        int pc_count;

        vecs[0] = '{"dec_ldi",   OP_LDI,   6'b01_1011};
        vecs[1] = '{"dec_lds",   OP_LDS,   6'b01_1101};
        vecs[2] = '{"dec_add",   OP_ADD,   6'b10_0011};
        vecs[3] = '{"dec_addi",  OP_ADDI,  6'b10_1011};
        vecs[4] = '{"dec_wait0", OP_WAIT0, 6'b00_0011};
        vecs[5] = '{"dec_wait1", OP_WAIT1, 6'b00_0001};

        reset      = 1'b1;
        opCode     = OP_ADD;
        demoSwitch = 1'b0;
        #1;

        // Reset held three cycles with ADD presented
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_pcinc", pcInc, 1'b0);
            chk("reset_writereg", writeReg, 1'b0);
            chk("reset_busy", busy, 1'b0);
        end
        chk("reset_illegal", illegalOp, 1'b0);
        reset = 1'b0;
        #1;
        chk("reset_release_ctl", ctl, 6'b10_0011);

        // Single-cycle decode table, debounced switch still 0
        for (int i = 0; i < 6; i++) begin
            opCode = vecs[i].op;
            #1;
            chk(vecs[i].name, ctl, vecs[i].exp);
            chk("table_busy", busy, 1'b0);
            tick();
        end

        // Three-cycle glitch must be filtered
        opCode     = OP_WAIT1;
        demoSwitch = 1'b1;
        tick(); tick(); tick();
        demoSwitch = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("glitch_pcinc", pcInc, 1'b0);
        end

        // Clean rising edge reaches pcInc on the sixth edge
        demoSwitch = 1'b1;
        #1;
        chk("debounce_pre", pcInc, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("debounce_edge", pcInc, (k == 6));
        end
        opCode = OP_WAIT0;
        #1;
        chk("wait0_sw1", pcInc, 1'b0);
        tick();

        // LDS waits on the switch, rewriting the register each cycle
        reset      = 1'b1;
        demoSwitch = 1'b0;
        tick(); tick();
        reset  = 1'b0;
        opCode = OP_LDS;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("lds_wait_ctl", ctl, 6'b01_1101);
            tick();
        end
        demoSwitch = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("lds_pcinc", pcInc, (k == 6));
            chk("lds_writereg", writeReg, 1'b1);
            chk("lds_immsw", immSwitches, 1'b1);
        end

        // Single MUL: two stall cycles then one write
        opCode = OP_MUL;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("mul_busy", busy, (i < 2));
            chk("mul_pcinc", pcInc, (i == 2));
            chk("mul_writereg", writeReg, (i == 2));
            chk("mul_alufunc", aluFunc, ALU_MUL);
            tick();
        end
        opCode = OP_ADD;
        #1;
        chk("after_mul_ctl", ctl, 6'b10_0011);
        chk("after_mul_busy", busy, 1'b0);
        tick();

        // MUL then MULI back-to-back: six cycles, two writes
        opCode   = OP_MUL;
        wr_count = 0;
        pc_count = 0;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                opCode = OP_MULI;
                #1;
            end
            chk("b2b_busy", busy, ((i % 3) != 2));
            chk("b2b_writereg", writeReg, ((i % 3) == 2));
            chk("b2b_imm", aluImmediate, (i >= 3));
            wr_count += int'(writeReg);
            pc_count += int'(pcInc);
            tick();
        end
        chk("b2b_write_count", 8'(wr_count), 8'd2);
        chk("b2b_pcinc_count", 8'(pc_count), 8'd2);

        // Reset while in MUL_BUSY aborts without a write
        opCode = OP_MUL;
        #1;
        chk("abort_issue_busy", busy, 1'b1);
        tick();
        chk("abort_inbusy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_reset_wr", writeReg, 1'b0);
        chk("abort_reset_pc", pcInc, 1'b0);
        tick();
        chk("abort_reset_wr2", writeReg, 1'b0);
        reset  = 1'b0;
        opCode = OP_ADD;
        #1;
        chk("abort_add_ctl", ctl, 6'b10_0011);
        chk("abort_add_busy", busy, 1'b0);
        tick();
        chk("abort_add_ctl2", ctl, 6'b10_0011);
        opCode = OP_MUL;
        #1;
        chk("abort_idle_issue", busy, 1'b1);
        tick(); tick();
        chk("abort_remul_final", writeReg, 1'b1);
        tick();

        // Illegal opcode: NOP behaviour and sticky flag
        opCode = 6'h3F;
        #1;
        chk("illegal_wr", writeReg, 1'b0);
        chk("illegal_pc", pcInc, 1'b1);
        chk("illegal_flag_pre", illegalOp, 1'b0);
        tick();
        chk("illegal_flag_set", illegalOp, 1'b1);
        opCode = OP_ADD;
        tick(); tick();
        chk("illegal_sticky", illegalOp, 1'b1);
        chk("illegal_after_ctl", ctl, 6'b10_0011);
        reset = 1'b1;
        tick();
        chk("illegal_cleared", illegalOp, 1'b0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
